sysid_info_regs: RTL and testbench

//  Parametrised system-ID register bank on an Avalon-MM slave, for the Qsys/HPS lightweight bridge.

---
 rtl/sysid_pkg.sv | 19 +
 rtl/sysid_uptime_counter.sv | 39 +++
 rtl/sysid_info_regs.sv | 93 +++++++++
 tb/tb_sysid_info_regs.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sysid_pkg.sv
// Shared definitions for the system-ID register bank: the word map,
// the CONTROL bit positions and the register word type.
package sysid_pkg;

    typedef logic [31:0] word_t;

    localparam logic [2:0] ADDR_SYSID     = 3'd0;
    localparam logic [2:0] ADDR_TIMESTAMP = 3'd1;
    localparam logic [2:0] ADDR_VERSION   = 3'd2;
    localparam logic [2:0] ADDR_SCRATCH   = 3'd3;
    localparam logic [2:0] ADDR_UPTIME_LO = 3'd4;
    localparam logic [2:0] ADDR_UPTIME_HI = 3'd5;
    localparam logic [2:0] ADDR_CONTROL   = 3'd6;
    localparam logic [2:0] ADDR_CLKFREQ   = 3'd7;

    localparam int CTRL_EN  = 0;
    localparam int CTRL_CLR = 1;

endpackage

// File: rtl/sysid_uptime_counter.sv
// Free-running uptime counter with clear priority and a high-word snapshot
// taken whenever the low word is read, so 64-bit reads are coherent.
module sysid_uptime_counter
    import sysid_pkg::*;
#(
    parameter int CNT_W = 64
) (
    input  logic  clock,
    input  logic  reset,
    input  logic  en,
    input  logic  clr,
    input  logic  snap,
    output word_t count,
    output word_t hi_snap
);

    logic [CNT_W-1:0] cnt_q;

    // NOTE: state uses non-blocking assignments so every register samples
    // pre-edge values; the snapshot below relies on seeing the old cnt_q.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            hi_snap <= '0;
        end else begin
            if (clr) begin
                cnt_q <= '0;
            end else if (en) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (snap) begin
                hi_snap <= word_t'(cnt_q[CNT_W-1:32]);
            end
        end
    end

    assign count = cnt_q[31:0];

endmodule

// File: rtl/sysid_info_regs.sv
// System-ID register bank on an Avalon-MM slave: constant identity words,
// a scratch word, CONTROL and a coherent uptime counter, read latency 1.
module sysid_info_regs
    import sysid_pkg::*;
#(
    parameter word_t       SYSTEM_ID     = 32'h5761_2637,
    parameter word_t       TIMESTAMP     = 32'h0,
    parameter logic [15:0] VER_MAJOR     = 16'd2,
    parameter logic [15:0] VER_MINOR     = 16'd0,
    parameter word_t       CLK_HZ        = 32'd50_000_000,
    parameter int          CNT_W         = 64,
    parameter word_t       SCRATCH_RESET = 32'h0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [2:0]  address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic [3:0]  byteenable,
    output logic [31:0] readdata,
    output logic        readdatavalid
);

    word_t scratch;
    logic  ctrl_en;
    word_t uptime_lo;
    word_t uptime_hi;
    word_t rd_mux;
    logic  ctrl_wr;
    logic  cnt_clr;
    logic  cnt_snap;

    assign ctrl_wr  = write && (address == ADDR_CONTROL) && byteenable[0];
    assign cnt_clr  = ctrl_wr && writedata[CTRL_CLR];
    assign cnt_snap = read && (address == ADDR_UPTIME_LO);

    sysid_uptime_counter #(
        .CNT_W (CNT_W)
    ) u_uptime (
        .clock   (clock),
        .reset   (reset),
        .en      (ctrl_en),
        .clr     (cnt_clr),
        .snap    (cnt_snap),
        .count   (uptime_lo),
        .hi_snap (uptime_hi)
    );

    // NOTE: every combinational output gets a default first, so no path
    // through the case statement can infer a latch.
    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_SYSID:     rd_mux = SYSTEM_ID;
            ADDR_TIMESTAMP: rd_mux = TIMESTAMP;
            ADDR_VERSION:   rd_mux = {VER_MAJOR, VER_MINOR};
            ADDR_SCRATCH:   rd_mux = scratch;
            ADDR_UPTIME_LO: rd_mux = uptime_lo;
            ADDR_UPTIME_HI: rd_mux = uptime_hi;
            ADDR_CONTROL:   rd_mux[CTRL_EN] = ctrl_en;
            ADDR_CLKFREQ:   rd_mux = CLK_HZ;
            default:        rd_mux = '0;
        endcase
    end

    // The read mux sees pre-write state, so a same-cycle write to the
    // addressed register is returned as its old value.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            scratch       <= SCRATCH_RESET;
            ctrl_en       <= 1'b1;
            readdata      <= '0;
            readdatavalid <= 1'b0;
        end else begin
            readdatavalid <= read;
            if (read) begin
                readdata <= rd_mux;
            end
            if (write && (address == ADDR_SCRATCH)) begin
                for (int b = 0; b < 4; b++) begin
                    if (byteenable[b]) begin
                        scratch[8*b +: 8] <= writedata[8*b +: 8];
                    end
                end
            end
            if (ctrl_wr) begin
                ctrl_en <= writedata[CTRL_EN];
            end
        end
    end

endmodule

// File: tb/tb_sysid_info_regs.sv
// Self-checking bench for sysid_info_regs: vector table, directed corner
// sequences and random traffic against a transaction-level register model.
module tb_sysid_info_regs;

    localparam int          CNT_W     = 33;
    localparam logic [31:0] P_SYSID   = 32'h5761_2637;
    localparam logic [31:0] P_TS      = 32'h6500_1234;
    localparam logic [31:0] P_VERSION = 32'h0002_0000;
    localparam logic [31:0] P_CLK     = 32'd50_000_000;
    localparam logic [31:0] P_SCR_RST = 32'hA5A5_0F0F;
    localparam longint unsigned CNT_MASK = (64'd1 << CNT_W) - 64'd1;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  address = '0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [31:0] writedata = '0;
    logic [3:0]  byteenable = '0;
    logic [31:0] readdata;
    logic        readdatavalid;

    sysid_info_regs #(
        .SYSTEM_ID     (P_SYSID),
        .TIMESTAMP     (P_TS),
        .VER_MAJOR     (16'd2),
        .VER_MINOR     (16'd0),
        .CLK_HZ        (P_CLK),
        .CNT_W         (CNT_W),
        .SCRATCH_RESET (P_SCR_RST)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .address       (address),
        .read          (read),
        .write         (write),
        .writedata     (writedata),
        .byteenable    (byteenable),
        .readdata      (readdata),
        .readdatavalid (readdatavalid)
    );

    always #5 clock = ~clock;

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Reference model: register contents as plain values.
    logic [31:0]     m_scratch;
    bit              m_en;
    longint unsigned m_cnt;
    logic [31:0]     m_hi;
    logic [31:0]     m_rdata;
    bit              m_rvalid;

    function automatic void m_reset();
        m_scratch = P_SCR_RST;
        m_en      = 1'b1;
        m_cnt     = 0;
        m_hi      = '0;
        m_rdata   = '0;
        m_rvalid  = 1'b0;
    endfunction

    function automatic logic [31:0] m_read(input logic [2:0] a);
        case (a)
            3'd0: return P_SYSID;
            3'd1: return P_TS;
            3'd2: return P_VERSION;
            3'd3: return m_scratch;
            3'd4: return m_cnt[31:0];
            3'd5: return m_hi;
            3'd6: return {31'b0, m_en};
            default: return P_CLK;
        endcase
    endfunction

    function automatic void m_edge(input bit rd, input bit wr, input logic [2:0] a,
                                   input logic [31:0] wd, input logic [3:0] be);
        bit clr;
        m_rvalid = rd;
        if (rd) m_rdata = m_read(a);
        if (rd && a == 3'd4) m_hi = 32'(m_cnt >> 32);
        clr = wr && a == 3'd6 && be[0] && wd[1];
        if (clr) m_cnt = 0;
        else if (m_en) m_cnt = (m_cnt + 1) & CNT_MASK;
        if (wr && a == 3'd3)
            for (int b = 0; b < 4; b++)
                if (be[b]) m_scratch[8*b +: 8] = wd[8*b +: 8];
        if (wr && a == 3'd6 && be[0]) m_en = wd[0];
    endfunction

    logic [31:0] got_d;
    logic        got_v;

    // One bus cycle: drive at the falling edge, sample 1 time unit after the rising edge.
    task automatic step(input bit rd, input bit wr, input logic [2:0] a,
                        input logic [31:0] wd, input logic [3:0] be);
        read = rd; write = wr; address = a; writedata = wd; byteenable = be;
        @(posedge clock);
        m_edge(rd, wr, a, wd, be);
        #1;
        got_v = readdatavalid;
        got_d = readdata;
        check("model_valid", {31'b0, got_v}, {31'b0, m_rvalid});
        check("model_data", got_d, m_rdata);
        read = 1'b0; write = 1'b0;
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        check("rst_valid", {31'b0, readdatavalid}, 32'd0);
        check("rst_data", readdata, 32'd0);
        m_reset();
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    typedef struct {
        bit          rd;
        bit          wr;
        logic [2:0]  a;
        logic [31:0] wd;
        logic [3:0]  be;
        bit          ev;
        bit          chk;
        logic [31:0] ed;
    } vec_t;

    vec_t tbl[20];

    initial begin
        logic [31:0] v_a, v_b;

        tbl[0]  = '{1, 0, 3'd0, 32'h0,        4'h0, 1, 1, P_SYSID};
        tbl[1]  = '{1, 0, 3'd1, 32'h0,        4'h0, 1, 1, P_TS};
        tbl[2]  = '{1, 0, 3'd2, 32'h0,        4'h0, 1, 1, P_VERSION};
        tbl[3]  = '{1, 0, 3'd7, 32'h0,        4'h0, 1, 1, P_CLK};
        tbl[4]  = '{0, 0, 3'd0, 32'h0,        4'h0, 0, 1, P_CLK};
        tbl[5]  = '{0, 1, 3'd3, 32'hDEADBEEF, 4'hF, 0, 1, P_CLK};
        tbl[6]  = '{0, 1, 3'd3, 32'h00000011, 4'h1, 0, 0, 32'h0};
        tbl[7]  = '{1, 0, 3'd3, 32'h0,        4'h0, 1, 1, 32'hDEADBE11};
        tbl[8]  = '{0, 1, 3'd0, 32'hFFFFFFFF, 4'hF, 0, 0, 32'h0};
        tbl[9]  = '{1, 0, 3'd0, 32'h0,        4'h0, 1, 1, P_SYSID};
        tbl[10] = '{1, 0, 3'd6, 32'h0,        4'h0, 1, 1, 32'd1};
        tbl[11] = '{0, 1, 3'd6, 32'hFFFFFFFC, 4'hF, 0, 0, 32'h0};
        tbl[12] = '{1, 0, 3'd6, 32'h0,        4'h0, 1, 1, 32'd0};
        tbl[13] = '{0, 1, 3'd6, 32'h00000001, 4'hE, 0, 0, 32'h0};
        tbl[14] = '{1, 0, 3'd6, 32'h0,        4'h0, 1, 1, 32'd0};
        tbl[15] = '{0, 1, 3'd6, 32'h00000001, 4'h1, 0, 0, 32'h0};
        tbl[16] = '{1, 0, 3'd6, 32'h0,        4'h0, 1, 1, 32'd1};
        tbl[17] = '{1, 1, 3'd3, 32'h12345678, 4'hF, 1, 1, 32'hDEADBE11};
        tbl[18] = '{1, 0, 3'd3, 32'h0,        4'h0, 1, 1, 32'h12345678};
        tbl[19] = '{1, 0, 3'd5, 32'h0,        4'h0, 1, 1, 32'd0};

        @(negedge clock);
        do_reset();

        for (int i = 0; i < 20; i++) begin
            step(tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].wd, tbl[i].be);
            check($sformatf("vec%0d_valid", i), {31'b0, got_v}, {31'b0, tbl[i].ev});
            if (tbl[i].chk) check($sformatf("vec%0d_data", i), got_d, tbl[i].ed);
        end

        // Scratch returns to its reset value.
        do_reset();
        step(1, 0, 3'd3, 32'h0, 4'h0);
        check("scratch_reset", got_d, P_SCR_RST);

        // Disabled counter holds; CLR together with EN restarts from zero.
        step(0, 1, 3'd6, 32'h0, 4'h1);
        repeat (10) step(0, 0, 3'd0, 32'h0, 4'h0);
        step(1, 0, 3'd4, 32'h0, 4'h0);
        v_a = got_d;
        step(1, 0, 3'd4, 32'h0, 4'h0);
        v_b = got_d;
        check("hold_equal", v_b, v_a);
        step(0, 1, 3'd6, 32'h3, 4'h1);
        step(1, 0, 3'd4, 32'h0, 4'h0);
        check("clr_zero", got_d, 32'd0);
        step(1, 0, 3'd4, 32'h0, 4'h0);
        check("clr_count1", got_d, 32'd1);
        step(1, 0, 3'd6, 32'h0, 4'h0);
        check("ctrl_read", got_d, 32'd1);

        // Clear around a live low-word read.
        repeat (5) step(0, 0, 3'd0, 32'h0, 4'h0);
        step(1, 0, 3'd4, 32'h0, 4'h0);
        check("pre_clr_nonzero", {31'b0, got_d != 0}, 32'd1);
        step(1, 1, 3'd6, 32'h3, 4'h1);
        check("ctrl_rw_prewrite", got_d, 32'd1);
        step(1, 0, 3'd4, 32'h0, 4'h0);
        check("post_clr_small", {31'b0, got_d <= 32'd2}, 32'd1);

        // Wrap of the 33-bit counter and the coherent high word.
        force dut.u_uptime.cnt_q = 33'h0_FFFF_FFFF;
        release dut.u_uptime.cnt_q;
        m_cnt = 64'h0_FFFF_FFFF;
        step(1, 0, 3'd4, 32'h0, 4'h0);
        check("wrap_lo", got_d, 32'hFFFF_FFFF);
        step(1, 0, 3'd5, 32'h0, 4'h0);
        check("wrap_hi_pre", got_d, 32'd0);
        force dut.u_uptime.cnt_q = 33'h0_FFFF_FFFF;
        release dut.u_uptime.cnt_q;
        m_cnt = 64'h0_FFFF_FFFF;
        step(1, 0, 3'd4, 32'h0, 4'h0);
        step(1, 0, 3'd4, 32'h0, 4'h0);
        check("wrap_lo_next", got_d, 32'd0);
        step(1, 0, 3'd5, 32'h0, 4'h0);
        check("wrap_hi_post", got_d, 32'd1);

        // Random traffic; CONTROL writes mostly keep the counter enabled.
        for (int i = 0; i < 400; i++) begin
            bit          r_rd, r_wr;
            logic [2:0]  r_a;
            logic [31:0] r_wd;
            logic [3:0]  r_be;
            r_rd = ($urandom_range(0, 99) < 50);
            r_wr = ($urandom_range(0, 99) < 30);
            r_a  = 3'($urandom_range(0, 7));
            r_wd = $urandom;
            r_be = 4'($urandom_range(0, 15));
            if (r_a == 3'd6 && $urandom_range(0, 3) != 0) r_wd[0] = 1'b1;
            step(r_rd, r_wr, r_a, r_wd, r_be);
        end

        // Reset while a read is in flight: no response appears.
        read = 1'b1; address = 3'd0;
        #2 reset = 1'b1;
        #1;
        check("inflight_valid_now", {31'b0, readdatavalid}, 32'd0);
        @(posedge clock);
        #1;
        check("inflight_valid_edge", {31'b0, readdatavalid}, 32'd0);
        check("inflight_data", readdata, 32'd0);
        read = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        m_reset();
        step(0, 0, 3'd0, 32'h0, 4'h0);
        check("inflight_after", {31'b0, got_v}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
